// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared AXI4-Lite definitions for the ysyx_24110006 memory responder:
// response codes, channel FSM state encodings and the default base address.
package ysyx_24110006_axi_pkg;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ysyx_24110006_sram_array.sv
// Word storage with one byte-masked synchronous write port and one registered
// read port; a read and write to the same word in one cycle returns old data.
module ysyx_24110006_sram_array #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_widx,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_ridx,
    output logic [31:0]           o_rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) o_rdata <= '0;
        else if (i_re) o_rdata <= mem[i_ridx];
    end

endmodule

// File: rtl/ysyx_24110006_sram.sv
// AXI4-Lite memory responder with independent read and write channel FSMs,
// programmable per-channel response latency and SLVERR for out-of-range access.
module ysyx_24110006_sram
    import ysyx_24110006_axi_pkg::*;
#(
    parameter logic [31:0] BASE       = DEFAULT_BASE,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned WR_LAT     = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    input  logic [31:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready,
    output rd_state_t   o_rd_state,
    output wr_state_t   o_wr_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid is never withdrawn by this block before its handshake.
    localparam logic [32:0] SPAN = 33'(1) << (DEPTH_LOG2 + 2);

    if (RD_LAT > 15 || WR_LAT > 15) begin : g_lat_check
        $error("RD_LAT and WR_LAT must be in 0..15");
    end

    rd_state_t r_state;
    wr_state_t w_state;
    logic [3:0]  r_cnt, w_cnt;
    logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] arr_rdata;

    // A zero-latency transaction resolves on its handshake edge, so decode
    // looks at the live bus in IDLE and at the latched copy afterwards.
    logic        ar_hs, aw_hs, w_hs, wr_both, rd_enter, wr_enter;
    logic [31:0] rd_addr, rd_off, wr_addr, wr_off, wr_data;
    logic [3:0]  wr_strb;
    logic        rd_hit, wr_hit;

    assign ar_hs    = i_arvalid & o_arready;
    assign aw_hs    = i_awvalid & o_awready;
    assign w_hs     = i_wvalid & o_wready;
    assign rd_addr  = (r_state == R_IDLE) ? i_araddr : ar_addr_q;
    assign rd_off   = rd_addr - BASE;
    assign rd_hit   = {1'b0, rd_off} < SPAN;
    assign wr_addr  = aw_hs ? i_awaddr : aw_addr_q;
    assign wr_data  = w_hs ? i_wdata : w_data_q;
    assign wr_strb  = w_hs ? i_wstrb : w_strb_q;
    assign wr_off   = wr_addr - BASE;
    assign wr_hit   = {1'b0, wr_off} < SPAN;
    assign wr_both  = (w_state == W_IDLE) && (aw_hs || !o_awready) && (w_hs || !o_wready);
    assign rd_enter = ((r_state == R_IDLE) && ar_hs && (RD_LAT == 0)) ||
                      ((r_state == R_WAIT) && (r_cnt == 4'd1));
    assign wr_enter = (wr_both && (WR_LAT == 0)) ||
                      ((w_state == W_WAIT) && (w_cnt == 4'd1));

    ysyx_24110006_sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_we    (wr_enter & wr_hit),
        .i_widx  (wr_off[DEPTH_LOG2+1:2]),
        .i_wdata (wr_data),
        .i_wstrb (wr_strb),
        .i_re    (rd_enter),
        .i_ridx  (rd_off[DEPTH_LOG2+1:2]),
        .o_rdata (arr_rdata)
    );

    assign o_rdata    = (o_rresp == RESP_SLVERR) ? 32'h0 : arr_rdata;
    assign o_rd_state = r_state;
    assign o_wr_state = w_state;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            o_arready <= 1'b1;
            o_rvalid  <= 1'b0;
            o_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    ar_addr_q <= i_araddr;
                    r_cnt     <= 4'(RD_LAT);
                    o_arready <= 1'b0;
                    r_state   <= rd_enter ? R_RESP : R_WAIT;
                end
                R_WAIT: r_cnt <= r_cnt - 4'd1;
                R_RESP: if (i_rready) begin
                    r_state   <= R_IDLE;
                    o_rvalid  <= 1'b0;
                    o_arready <= 1'b1;
                end
                default: r_state <= R_IDLE;
            endcase
            if (rd_enter) begin
                r_state  <= R_RESP;
                o_rvalid <= 1'b1;
                o_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            o_awready <= 1'b1;
            o_wready  <= 1'b1;
            o_bvalid  <= 1'b0;
            o_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= i_awaddr;
                        o_awready <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data_q <= i_wdata;
                        w_strb_q <= i_wstrb;
                        o_wready <= 1'b0;
                    end
                    if (wr_both) begin
                        w_cnt   <= 4'(WR_LAT);
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: w_cnt <= w_cnt - 4'd1;
                W_RESP: if (i_bready) begin
                    w_state   <= W_IDLE;
                    o_bvalid  <= 1'b0;
                    o_awready <= 1'b1;
                    o_wready  <= 1'b1;
                end
                default: w_state <= W_IDLE;
            endcase
            if (wr_enter) begin
                w_state  <= W_RESP;
                o_bvalid <= 1'b1;
                o_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: doc/ysyx_24110006_sram.md
Name: ysyx_24110006_sram

Overview:
- AXI4-Lite memory responder (slave) for the core's IFU and LSU initiators, which issue valid-qualified fetch/load/store requests.
- Internal word-addressed storage; independent read (AR/R) and write (AW/W/B) channels.
- Programmable response latency per channel, so the multi-cycle pipeline's valid handshakes are exercised under wait states.
- Out-of-range accesses return SLVERR.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of word count (4096 words = 16 KiB).
- RD_LAT, 1, cycles between AR accept and rvalid assertion (0..15).
- WR_LAT, 1, cycles between AW+W both held and bvalid assertion (0..15).

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_araddr  in  32  read address.
- i_arvalid  in  1  read address valid.
- o_arready  out  1  read address ready.
- o_rdata  out  32  read data.
- o_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- o_rvalid  out  1  read data valid.
- i_rready  in  1  read data ready.
- i_awaddr  in  32  write address.
- i_awvalid  in  1  write address valid.
- o_awready  out  1  write address ready.
- i_wdata  in  32  write data.
- i_wstrb  in  4  byte strobes; bit n enables byte lane n.
- i_wvalid  in  1  write data valid.
- o_wready  out  1  write data ready.
- o_bresp  out  2  write response.
- o_bvalid  out  1  write response valid.
- i_bready  in  1  write response ready.

Behaviour:
- Reset (async, immediate): o_arready=1, o_awready=1, o_wready=1, o_rvalid=0, o_bvalid=0, o_rdata=0, o_rresp=0, o_bresp=0.
  - Both FSMs go to IDLE; latency counters clear; in-flight transactions are dropped.
  - Memory contents are not reset.
- Address decode:
  - off = addr - BASE.
  - in range iff off < (1<<(DEPTH_LOG2+2)).
  - Word index = off[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: o_arready=1. On arvalid: latch addr, load counter with RD_LAT. Go to R_WAIT, or to R_RESP directly if RD_LAT=0.
  - R_WAIT: o_arready=0; counter decrements; at 1 -> R_RESP.
  - Entering R_RESP: capture o_rdata = mem[idx] and o_rresp=00 if in range; otherwise o_rdata=0, o_rresp=10. Assert o_rvalid.
  - R_RESP: o_rvalid, o_rdata, o_rresp held stable until i_rready; on rvalid&rready -> R_IDLE, o_rvalid=0 next cycle.
  - One outstanding read; no AR accepted before R handshake completes.
  - Latency, RD_LAT=1 and rready held high: AR handshake at cycle N, rvalid at N+2, arready high again at N+3.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AW and W are accepted independently.
    - o_awready stays 1 until AW is latched; o_wready stays 1 until W (data, strb) is latched. Each drops after its own handshake.
    - Same-cycle AW+W is legal.
  - Once both are latched: load counter with WR_LAT -> W_WAIT (W_RESP if WR_LAT=0).
  - Entering W_RESP:
    - In range: write mem[idx] byte lanes per latched wstrb; wstrb=0 performs no write, bresp=00.
    - Out of range: no write, bresp=10.
    - Assert o_bvalid.
  - W_RESP: o_bvalid, o_bresp held until i_bready; then -> W_IDLE with awready=wready=1.
- Read/write interaction:
  - Channels run concurrently.
  - If a read enters R_RESP in the same cycle a write commits to the same word, the read returns the pre-write data.
  - A read entering R_RESP after the commit cycle returns the new data.
- Counters are 4 bits wide. Any RD_LAT/WR_LAT value >15 is a parameter error, checked by an elaboration-time assertion.

Decomposition:
- Shared package ysyx_24110006_axi_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - read and write FSM state enums;
  - the BASE default.
- One sub-module, ysyx_24110006_sram_array: storage with one byte-masked synchronous write port and one synchronous read port, read-before-write on collision.

Test Plan:
- Write/read back: AW=0x8000_0010, W=0xDEADBEEF, wstrb=0xF, bready=1 -> bresp=00 after WR_LAT+1 cycles; then AR=0x8000_0010 -> rdata=0xDEADBEEF, rresp=00, rvalid at cycle N+2.
- Byte strobe: preload 0x11223344 at 0x8000_0020, write 0xAABBCCDD with wstrb=0b0101 -> readback 0x11BB33DD.
- Out of range: AR=0x7FFF_FFFC -> rresp=10, rdata=0. AW=0x8001_0000 with wdata=0xFFFFFFFF -> bresp=10, and memory word 0 is unchanged.
- Backpressure: hold rready=0 for 5 cycles after rvalid -> rvalid and rdata stable for all 5 cycles; arready=0 throughout; completes on the first rready=1.
- Split write: W valid at cycle N, AW valid at cycle N+3 -> wready=0 from N+1, awready accepted at N+3, bvalid at N+3+WR_LAT+1.
- Reset mid-transaction: assert i_reset during R_WAIT -> o_rvalid=0 and o_arready=1 asynchronously; previously written data is still readable after reset release.
